// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Transmit line driver fed directly by the UART TX FIFO. A byte is taken over
// the tx_wren/tx_accept handshake and shifted out on txd LSB first as
// start + 8 data + STOP_BITS stop bits, each bit lasting CLKS_PER_BIT sys_clk
// cycles. tx_accept pulses once per byte so the FIFO can advance its read
// address.
//
// Optional build macro: UART_TX_PARITY_EN
//   When defined, an even-parity bit (XOR of the 8 data bits) is inserted
//   between the last data bit and the stop bit(s).
//
// Parameters:
//   CLKS_PER_BIT  sys_clk cycles per bit, 2..65535 (default 434)
//   STOP_BITS     1 or 2; any other value behaves as 1
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   tx_wren    in   FIFO has a byte on tx_data (level)
//   tx_data    in   byte to send, valid while tx_wren=1
//   tx_accept  out  one-cycle pulse on the first start-bit cycle (byte latched)
//   txd        out  serial line, idle high
//   tx_busy    out  high from the accept edge until the return to IDLE
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       sys_clk,
   input  logic       reset_n,
   input  logic       tx_wren,
   input  logic [7:0] tx_data,
   output logic       tx_accept,
   output logic       txd,
   output logic       tx_busy
);

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   // Index of the final stop bit; anything but 2 stop bits collapses to 1.
   localparam logic [2:0]  STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t      state_q, state_d;
   logic [15:0] baud_q, baud_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        txd_q, txd_d;
   logic        tx_accept_q, tx_accept_d;
   logic        tx_busy_q, tx_busy_d;
`ifdef UART_TX_PARITY_EN
   logic        parity_q, parity_d;
`endif

   logic        bit_end;

   assign bit_end = (baud_q == BAUD_LAST);

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         txd_q       <= 1'b1;
         tx_accept_q <= 1'b0;
         tx_busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         txd_q       <= txd_d;
         tx_accept_q <= tx_accept_d;
         tx_busy_q   <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      txd_d       = txd_q;
      tx_accept_d = 1'b0;        // pulse only: cleared on every edge it is not set
      tx_busy_d   = tx_busy_q;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif

      // The baud counter free-runs through a frame; the wrap edge is the bit boundary.
      if (state_q != IDLE) begin
         baud_d = bit_end ? 16'd0 : baud_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            baud_d    = '0;
            bit_cnt_d = '0;
            if (tx_wren) begin
               shift_d     = tx_data;
               tx_accept_d = 1'b1;
               txd_d       = 1'b0;
               tx_busy_d   = 1'b1;
               state_d     = START;
`ifdef UART_TX_PARITY_EN
               parity_d    = ^tx_data;
`endif
            end
         end

         START: begin
            if (bit_end) begin
               txd_d   = shift_q[0];
               state_d = DATA;
            end
         end

         DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                  txd_d     = parity_q;
                  state_d   = PARITY;
`else
                  txd_d     = 1'b1;
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  // shift_q[1] is the bit that becomes shift[0] on this edge
                  txd_d     = shift_q[1];
               end
            end
         end

`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               txd_d   = 1'b1;
               state_d = STOP;
            end
         end
`endif

         STOP: begin
            // bit_cnt is reused to count stop bits
            if (bit_end) begin
               if (bit_cnt_q == STOP_LAST) begin
                  bit_cnt_d = '0;
                  tx_busy_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign txd       = txd_q;
   assign tx_accept = tx_accept_q;
   assign tx_busy   = tx_busy_q;

endmodule
